// File: rtl/memory_unit_pkg.sv
// Shared encodings for the memory stage: load/store funct3 values, counter CSR
// addresses and the bubble instruction word.
package memory_unit_pkg;

  localparam logic [31:0] NOP_INSTR_WORD = 32'h00000033;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_TIMEH    = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

endpackage

// File: rtl/memory_unit_if.sv
// EM-in / DMem-write / MW-out bundle of the memory stage. The stage itself is
// the slave; the surrounding pipeline (or a bench) is the master.
interface memory_unit_if;
  logic        M_stall_i;
  logic        W_flush_i;
  logic [31:0] EM_PC_i;
  logic [31:0] EM_instr_i;
  logic        EM_nop_i;
  logic        EM_isLoad_i;
  logic        EM_isStore_i;
  logic        EM_isCSR_i;
  logic [5:0]  EM_rdId_i;
  logic [11:0] EM_csrId_i;
  logic [2:0]  EM_funct3_i;
  logic [31:0] EM_rs2_i;
  logic [31:0] EM_Eresult_i;
  logic [31:0] EM_addr_i;
  logic [31:0] EM_Mdata_i;
  logic        EM_wbEnable_i;
  logic [31:0] DMemWAddr_o;
  logic [31:0] DMemWData_o;
  logic [3:0]  DMemWMask_o;
  logic [31:0] MW_PC_o;
  logic [31:0] MW_instr_o;
  logic        MW_nop_o;
  logic [5:0]  MW_rdId_o;
  logic [31:0] MW_wbData_o;
  logic        MW_wbEnable_o;

  modport master (
    output M_stall_i, W_flush_i, EM_PC_i, EM_instr_i, EM_nop_i, EM_isLoad_i,
           EM_isStore_i, EM_isCSR_i, EM_rdId_i, EM_csrId_i, EM_funct3_i,
           EM_rs2_i, EM_Eresult_i, EM_addr_i, EM_Mdata_i, EM_wbEnable_i,
    input  DMemWAddr_o, DMemWData_o, DMemWMask_o, MW_PC_o, MW_instr_o,
           MW_nop_o, MW_rdId_o, MW_wbData_o, MW_wbEnable_o
  );

  modport slave (
    input  M_stall_i, W_flush_i, EM_PC_i, EM_instr_i, EM_nop_i, EM_isLoad_i,
           EM_isStore_i, EM_isCSR_i, EM_rdId_i, EM_csrId_i, EM_funct3_i,
           EM_rs2_i, EM_Eresult_i, EM_addr_i, EM_Mdata_i, EM_wbEnable_i,
    output DMemWAddr_o, DMemWData_o, DMemWMask_o, MW_PC_o, MW_instr_o,
           MW_nop_o, MW_rdId_o, MW_wbData_o, MW_wbEnable_o
  );
endinterface

// File: rtl/memory_unit_counter_csr.sv
// Read-only RV32 cycle/instret counters; rdata_o returns the value held
// before this cycle's increment.
module counter_csr
  import memory_unit_pkg::*;
#(
  parameter int unsigned COUNTER_W = 64
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 retire_i,
  input  logic                 preload_i,
  input  logic [COUNTER_W-1:0] preload_val_i,
  input  logic [11:0]          csrId_i,
  output logic [31:0]          rdata_o
);

  logic [COUNTER_W-1:0] cycle_q;
  logic [COUNTER_W-1:0] instret_q;
  logic [63:0]          cycle_w;
  logic [63:0]          instret_w;

  // preload_i is a debug hook that seeds the cycle counter; tied low in use
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= preload_i ? preload_val_i : cycle_q + COUNTER_W'(1);
      if (retire_i) instret_q <= instret_q + COUNTER_W'(1);
    end
  end

  assign cycle_w   = 64'(cycle_q);
  assign instret_w = 64'(instret_q);

  always_comb begin
    rdata_o = '0;
    case (csrId_i)
      CSR_CYCLE, CSR_TIME:   rdata_o = cycle_w[31:0];
      CSR_CYCLEH, CSR_TIMEH: rdata_o = cycle_w[63:32];
      CSR_INSTRET:           rdata_o = instret_w[31:0];
      CSR_INSTRETH:          rdata_o = instret_w[63:32];
      default:               rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/memory_unit.sv
// Memory stage: store lane generation, load extraction, counter CSR reads and
// the MW pipeline register feeding writeback and forwarding.
module memory_unit
  import memory_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD,
  parameter int unsigned COUNTER_W = 64
) (
  input  logic         clk_i,
  input  logic         reset_i,
  memory_unit_if.slave bus
);

  function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                               input logic [1:0] off,
                                               input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = $signed(word[{off, 3'b000} +: 8]);
    h = $signed(off[1] ? word[31:16] : word[15:0]);
    case (f3)
      F3_LB:   load_extract = 32'(b);
      F3_LH:   load_extract = 32'(h);
      F3_LW:   load_extract = word;
      F3_LBU:  load_extract = {24'h0, b};
      F3_LHU:  load_extract = {16'h0, h};
      default: load_extract = '0;
    endcase
  endfunction

  logic                 store_ok;
  logic                 retire;
  logic [31:0]          csr_rdata;
  logic [31:0]          wb_data;
  logic                 cycle_preload;
  logic [COUNTER_W-1:0] cycle_preload_val;

  logic [31:0] pc_p1;
  logic [31:0] instr_p1;
  logic        nop_p1;
  logic [5:0]  rd_p1;
  logic [31:0] wb_data_p1;
  logic        wb_en_p1;

  assign cycle_preload     = 1'b0;
  assign cycle_preload_val = '0;
  assign retire = !bus.M_stall_i && !bus.W_flush_i && !bus.EM_nop_i;

  counter_csr #(.COUNTER_W(COUNTER_W)) u_csr (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .retire_i      (retire),
    .preload_i     (cycle_preload),
    .preload_val_i (cycle_preload_val),
    .csrId_i       (bus.EM_csrId_i),
    .rdata_o       (csr_rdata)
  );

  // Stage p0: combinational store lanes; gating on stall makes a held store write once
  always_comb begin
    store_ok        = bus.EM_isStore_i && !bus.EM_nop_i && !bus.M_stall_i && reset_i;
    bus.DMemWAddr_o = {bus.EM_addr_i[31:2], 2'b00};
    bus.DMemWData_o = bus.EM_rs2_i;
    bus.DMemWMask_o = '0;
    case (bus.EM_funct3_i)
      F3_SB: begin
        bus.DMemWData_o = {4{bus.EM_rs2_i[7:0]}};
        bus.DMemWMask_o = 4'b0001 << bus.EM_addr_i[1:0];
      end
      F3_SH: begin
        bus.DMemWData_o = {2{bus.EM_rs2_i[15:0]}};
        bus.DMemWMask_o = bus.EM_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      F3_SW:   bus.DMemWMask_o = 4'b1111;
      default: bus.DMemWMask_o = '0;
    endcase
    if (!store_ok) bus.DMemWMask_o = '0;
  end

  always_comb begin
    wb_data = bus.EM_Eresult_i;
    if (bus.EM_isLoad_i)
      wb_data = load_extract(bus.EM_funct3_i, bus.EM_addr_i[1:0], bus.EM_Mdata_i);
    else if (bus.EM_isCSR_i)
      wb_data = csr_rdata;
  end

  // Stage p1: MW register; flush only bubbles the control fields
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      pc_p1      <= '0;
      instr_p1   <= NOP_INSTR;
      nop_p1     <= 1'b1;
      rd_p1      <= '0;
      wb_data_p1 <= '0;
      wb_en_p1   <= 1'b0;
    end else begin
      if (!bus.M_stall_i) begin
        pc_p1      <= bus.EM_PC_i;
        rd_p1      <= bus.EM_rdId_i;
        wb_data_p1 <= wb_data;
      end
      if (bus.W_flush_i) begin
        instr_p1 <= NOP_INSTR;
        nop_p1   <= 1'b1;
        wb_en_p1 <= 1'b0;
      end else if (!bus.M_stall_i) begin
        instr_p1 <= bus.EM_instr_i;
        nop_p1   <= bus.EM_nop_i;
        wb_en_p1 <= bus.EM_wbEnable_i;
      end
    end
  end

  assign bus.MW_PC_o       = pc_p1;
  assign bus.MW_instr_o    = instr_p1;
  assign bus.MW_nop_o      = nop_p1;
  assign bus.MW_rdId_o     = rd_p1;
  assign bus.MW_wbData_o   = wb_data_p1;
  assign bus.MW_wbEnable_o = wb_en_p1;

endmodule
